text_stream_generator: RTL and testbench

TEXT_STREAM_GENERATOR -- requirements
Module: text_stream_generator

---
 rtl/text_stream_generator.sv | 190 +++++++++++++++++++
 tb/tb_text_stream_generator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_stream_generator.sv
// Streams a text screen as vertical 8-pixel column bytes, band-major, through a 2-stage fetch pipe and output FIFO.
// Define TEXT_STREAM_SCROLL_EN to add the scroll_col input (horizontal fetch offset sampled at each frame start).
module text_stream_generator #(
  parameter int TEXT_WIDTH  = 16,
  parameter int TEXT_HEIGHT = 4,
  parameter int CHAR_HEIGHT = 16,
  parameter int FIFO_DEPTH  = 4,
  localparam int COLS  = TEXT_WIDTH * 8,
  localparam int BANDS = TEXT_HEIGHT * CHAR_HEIGHT / 8,
  localparam int TSZ   = $clog2(TEXT_WIDTH * TEXT_HEIGHT),
  localparam int RSZ   = $clog2(256 * CHAR_HEIGHT),
  localparam int TW    = (TSZ > 0) ? TSZ : 1,
  localparam int CW    = $clog2(COLS),
  localparam int BW    = (BANDS > 1) ? $clog2(BANDS) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic           continuous,
`ifdef TEXT_STREAM_SCROLL_EN
  input  logic [CW-1:0]  scroll_col,
`endif
  output logic [TW-1:0]  text_rd_addr,
  input  logic [7:0]     text_rd_data,
  output logic [RSZ-1:0] rom_rd_addr,
  input  logic [7:0]     rom_rd_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_char,
  output logic [7:0]     out_pixels,
  output logic [CW-1:0]  out_col,
  output logic [BW-1:0]  out_band,
  output logic           out_eol,
  output logic           out_eof,
  output logic           busy
);

  localparam int BPR = CHAR_HEIGHT / 8;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FW  = 8 + 8 + CW + BW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]  col_p0, fcol_p0, col_p1, col_p2;
  logic [BW-1:0]  band_p0, band_p1, band_p2;
  logic [1:0]     sub_p0, sub_p1;
  logic [2:0]     fcl_p1;
  logic           last_col_p0, last_beat_p0, issue_p0;
  logic           vld_p1, vld_p2;
  logic           eol_p1, eol_p2, eof_p1, eof_p2;
  logic [7:0]     char_p2;
  logic [FW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    fifo_cnt;
  logic [PW+1:0]  occ;
  logic           push, pop, head_eol, head_eof;

  // Stage p0: issue decision, position counters, text RAM address
  always_comb begin
    last_col_p0  = (col_p0 == CW'(COLS - 1));
    last_beat_p0 = last_col_p0 && (band_p0 == BW'(BANDS - 1));
    occ          = (PW+2)'(fifo_cnt) + (PW+2)'(vld_p1) + (PW+2)'(vld_p2);
    issue_p0     = (state == RUN) && !abort && (occ < (PW+2)'(FIFO_DEPTH));
    sub_p0       = 2'(int'(band_p0) % BPR);
    text_rd_addr = TW'(int'(fcol_p0) / 8 + (int'(band_p0) / BPR) * TEXT_WIDTH);
  end

`ifdef TEXT_STREAM_SCROLL_EN
  logic [CW-1:0] scroll_q, scroll_red;
  logic [CW:0]   fsum;
  logic          frame_start;

  // scroll_col may exceed COLS-1 when COLS is not a power of two; fold it once at sampling
  always_comb begin
    scroll_red  = (int'(scroll_col) >= COLS) ? CW'(int'(scroll_col) - COLS) : scroll_col;
    fsum        = {1'b0, col_p0} + {1'b0, scroll_q};
    fcol_p0     = (int'(fsum) >= COLS) ? CW'(int'(fsum) - COLS) : fsum[CW-1:0];
    frame_start = ((state == IDLE) && start && !abort) || (issue_p0 && last_beat_p0 && continuous);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         scroll_q <= '0;
    else if (frame_start) scroll_q <= scroll_red;
  end
`else
  assign fcol_p0 = col_p0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_p0  <= '0;
      band_p0 <= '0;
    end else if (abort) begin
      col_p0  <= '0;
      band_p0 <= '0;
    end else if (issue_p0) begin
      if (last_col_p0) begin
        col_p0  <= '0;
        band_p0 <= (band_p0 == BW'(BANDS - 1)) ? '0 : band_p0 + BW'(1);
      end else begin
        col_p0  <= col_p0 + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (issue_p0 && last_beat_p0) state_nx = continuous ? RUN : DRAIN;
      DRAIN:   if ((fifo_cnt == '0) && !vld_p1 && !vld_p2) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (abort) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p1: character code returns, font ROM address formed
  always_ff @(posedge clk) begin
    col_p1  <= col_p0;
    band_p1 <= band_p0;
    eol_p1  <= last_col_p0;
    eof_p1  <= last_beat_p0;
    sub_p1  <= sub_p0;
    fcl_p1  <= fcol_p0[2:0];
  end

  assign rom_rd_addr = vld_p1 ? RSZ'(int'(text_rd_data) * CHAR_HEIGHT + int'(sub_p1) * 8 + int'(fcl_p1))
                              : '0;

  // Stage p2: pixel byte returns and the beat is written to the FIFO
  always_ff @(posedge clk) begin
    col_p2  <= col_p1;
    band_p2 <= band_p1;
    eol_p2  <= eol_p1;
    eof_p2  <= eof_p1;
    char_p2 <= text_rd_data;
  end

  assign push = vld_p2;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {char_p2, rom_rd_data, col_p2, band_p2, eol_p2, eof_p2};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign {out_char, out_pixels, out_col, out_band, head_eol, head_eof} = fifo_mem[rd_ptr];
  // Frame flags are qualified so they read low whenever nothing is presented
  assign out_eol = out_valid && head_eol;
  assign out_eof = out_valid && head_eof;

endmodule

// File: tb/tb_text_stream_generator.sv
// Directed bench for text_stream_generator: RAM/ROM models, a frame-level reference model and a per-cycle compare loop.
module tb_text_stream_generator;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] px;
    logic [6:0] col;
    logic [2:0] band;
    logic       eol;
    logic       eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, continuous, out_ready;
  logic [5:0]  text_rd_addr;
  logic [7:0]  text_rd_data;
  logic [11:0] rom_rd_addr;
  logic [7:0]  rom_rd_data;
  logic        out_valid, out_eol, out_eof, busy;
  logic [7:0]  out_char, out_pixels;
  logic [6:0]  out_col;
  logic [2:0]  out_band;
`ifdef TEXT_STREAM_SCROLL_EN
  logic [6:0]  scroll_col;
`endif

  logic [7:0]  tram [64];
  logic        rdy_val, rand_rdy, rnd_bit, chk_en, prev_stall;
  logic [27:0] snap;
  int          cyc = 0, n_pass = 0, n_total = 0;
  int          beat_idx = 0, base = 0, gaps = 0, last_cyc = 0, eol_cnt = 0, eof_cnt = 0;
  int          scroll_m = 0;
  int          g0, e0, f0;

  text_stream_generator dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .continuous(continuous),
`ifdef TEXT_STREAM_SCROLL_EN
    .scroll_col(scroll_col),
`endif
    .text_rd_addr(text_rd_addr), .text_rd_data(text_rd_data),
    .rom_rd_addr(rom_rd_addr), .rom_rd_data(rom_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .out_pixels(out_pixels), .out_col(out_col), .out_band(out_band),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = rand_rdy ? rnd_bit : rdy_val;

  function automatic logic [7:0] rom_fn(input int ra);
    logic [11:0] a;
    a = 12'(ra);
    return a[7:0] ^ {4'h0, a[11:8]};
  endfunction

  always @(posedge clk) begin
    text_rd_data <= tram[text_rd_addr];
    rom_rd_data  <= rom_fn(int'(rom_rd_addr));
  end

  // Reference: beat k of a frame, straight from screen geometry
  function automatic beat_t model_beat(input int k);
    beat_t m;
    int b, c, fc, a, ra;
    b  = k / 128;
    c  = k % 128;
    fc = (c + scroll_m) % 128;
    a  = fc / 8 + (b / 2) * 16;
    ra = int'(tram[a]) * 16 + (b % 2) * 8 + fc % 8;
    m.ch   = tram[a];
    m.px   = rom_fn(ra);
    m.col  = 7'(c);
    m.band = 3'(b);
    m.eol  = (c == 127);
    m.eof  = (k == 1023);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cmp_step();
    beat_t e;
    int    rel;
    if (!chk_en) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_hold", 32'({out_char, out_pixels, out_col, out_band, out_eol, out_eof}), 32'(snap));
    end
    if (out_valid && out_ready) begin
      rel = beat_idx - base;
      e   = model_beat(rel % 1024);
      chk($sformatf("beat%0d_char", rel), 32'(out_char), 32'(e.ch));
      chk($sformatf("beat%0d_pix", rel), 32'(out_pixels), 32'(e.px));
      chk($sformatf("beat%0d_col", rel), 32'(out_col), 32'(e.col));
      chk($sformatf("beat%0d_band", rel), 32'(out_band), 32'(e.band));
      chk($sformatf("beat%0d_flags", rel), 32'({out_eol, out_eof}), 32'({e.eol, e.eof}));
      if (rel > 0 && cyc != last_cyc + 1) gaps++;
      if (out_eol) eol_cnt++;
      if (out_eof) eof_cnt++;
      last_cyc = cyc;
      beat_idx++;
    end
    prev_stall = out_valid && !out_ready;
    snap       = {out_char, out_pixels, out_col, out_band, out_eol, out_eof};
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 50);
    chk(nm, 32'(out_valid), 1);
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    int k = 0;
    while ((beat_idx - base) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(nm, ((beat_idx - base) >= n) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_valid"}, 32'(out_valid), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_eol"}, 32'(out_eol), 0);
    chk({pfx, "_eof"}, 32'(out_eof), 0);
    chk({pfx, "_taddr"}, 32'(text_rd_addr), 0);
    chk({pfx, "_raddr"}, 32'(rom_rd_addr), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    rdy_val = 1'b1; rand_rdy = 1'b0; chk_en = 1'b0; prev_stall = 1'b0; snap = '0;
`ifdef TEXT_STREAM_SCROLL_EN
    scroll_col = '0;
`endif
    for (int i = 0; i < 64; i++) tram[i] = 8'h41;
    fork
      forever begin
        @(negedge clk);
        cmp_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk_en = 1'b1;

    // Full frame, ready held high
    base = beat_idx; g0 = gaps; e0 = eol_cnt; f0 = eof_cnt;
    pulse_start();
    wait_valid("t1_first_valid");
    chk("t1_first_char", 32'(out_char), 32'h41);
    chk("t1_first_pix", 32'(out_pixels), 32'h14);
    chk("t1_first_col", 32'(out_col), 0);
    chk("t1_first_band", 32'(out_band), 0);
    chk("t1_busy", 32'(busy), 1);
    wait_beats(1024, 3000, "t1_done");
    repeat (10) @(posedge clk);
    #1 chk("t1_beats", 32'(beat_idx - base), 1024);
    chk("t1_gaps", 32'(gaps - g0), 0);
    chk("t1_eols", 32'(eol_cnt - e0), 8);
    chk("t1_eofs", 32'(eof_cnt - f0), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_valid_end", 32'(out_valid), 0);

    // Random backpressure
    base = beat_idx; rand_rdy = 1'b1;
    pulse_start();
    wait_beats(1024, 8000, "t2_done");
    #1 rand_rdy = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("t2_beats", 32'(beat_idx - base), 1024);
    chk("t2_busy_end", 32'(busy), 0);

    // Ready low from the start: buffer fills, issue stops
    base = beat_idx; rdy_val = 1'b0;
    pulse_start();
    repeat (10) @(posedge clk);
    #1 chk("t3_valid_a", 32'(out_valid), 1);
    chk("t3_taddr_a", 32'(text_rd_addr), 0);
    repeat (20) @(posedge clk);
    #1 chk("t3_valid_b", 32'(out_valid), 1);
    chk("t3_taddr_b", 32'(text_rd_addr), 0);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_beats_held", 32'(beat_idx - base), 0);
    rdy_val = 1'b1;
    wait_beats(1024, 3000, "t3_done");
    repeat (10) @(posedge clk);
    #1 chk("t3_beats", 32'(beat_idx - base), 1024);
    chk("t3_busy_end", 32'(busy), 0);

    // Abort with simultaneous start, then restart on different text
    base = beat_idx;
    pulse_start();
    wait_beats(300, 1000, "t4_reach300");
    #1 abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    chk("t4_valid_next", 32'(out_valid), 0);
    chk("t4_busy_next", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1 chk("t4_valid_later", 32'(out_valid), 0);
    chk("t4_busy_later", 32'(busy), 0);
    for (int i = 0; i < 64; i++) tram[i] = 8'(i * 5 + 3);
    base = beat_idx;
    pulse_start();
    wait_valid("t4_restart_valid");
    chk("t4_restart_col", 32'(out_col), 0);
    chk("t4_restart_band", 32'(out_band), 0);
    chk("t4_restart_char", 32'(out_char), 32'h03);
    chk("t4_restart_pix", 32'(out_pixels), 32'h30);
    wait_beats(1024, 3000, "t4_done");
    repeat (10) @(posedge clk);
    #1 chk("t4_busy_end", 32'(busy), 0);
    for (int i = 0; i < 64; i++) tram[i] = 8'h41;

    // Continuous frames, then reset mid-frame
    continuous = 1'b1; base = beat_idx; g0 = gaps; f0 = eof_cnt;
    pulse_start();
    wait_beats(1524, 3000, "t5_reach1524");
    chk("t5_gaps", 32'(gaps - g0), 0);
    chk("t5_eofs", 32'(eof_cnt - f0), 1);
    chk("t5_busy", 32'(busy), 1);
    #1 chk_en = 1'b0; reset_n = 1'b0;
    #1 chk_reset_vals("t5_rst");
    @(posedge clk); #1 reset_n = 1'b1; continuous = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_valid", 32'(out_valid), 0);
    chk_en = 1'b1;

`ifdef TEXT_STREAM_SCROLL_EN
    // Scrolled fetch: column 0 shows character cell 1
    tram[1] = 8'h42; scroll_col = 7'd8; scroll_m = 8; base = beat_idx;
    pulse_start();
    wait_valid("t6_valid");
    chk("t6_char", 32'(out_char), 32'h42);
    chk("t6_col", 32'(out_col), 0);
    wait_beats(1024, 3000, "t6_done");
    repeat (10) @(posedge clk);
    #1 chk("t6_busy_end", 32'(busy), 0);
    scroll_col = '0; scroll_m = 0; tram[1] = 8'h41;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
